// File: rtl/ibex_rf_writeback_stage.sv
// ----------------------------------------------------------------------------
// ibex_rf_writeback_stage
//
// Single-entry writeback stage between EX/LSU and write port W1 of the
// flip-flop register file. It holds one retiring instruction. A non-load entry
// retires in the cycle after capture. A load entry waits for its LSU response
// and then retires. The stage also reports an outstanding load to ID, and
// qualifies dummy-instruction writes. It keeps a saturating count of the
// cycles spent waiting for load data.
//
// Handshake: an instruction is transferred from EX when en_wb_i && ready_wb_o
// are both high at a rising clk_i edge. ready_wb_o depends only on the held
// state and lsu_resp_valid_i, never on en_wb_i. EX must not raise en_wb_i
// while ready_wb_o is low. If it does, the request is dropped and the held
// entry is kept.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   en_wb_i                instruction from EX enters WB this cycle
//   instr_is_load_i        entering instruction is a load
//   dummy_instr_id_i       entering instruction is a dummy
//   rf_waddr_ex_i          destination register
//   rf_wdata_ex_i          ALU/CSR result (ignored for loads)
//   rf_we_ex_i             instruction writes the register file
//   lsu_resp_valid_i       load data returns this cycle
//   lsu_rdata_i            load data
//   lsu_resp_err_i         load bus error
//   ready_wb_o             WB can accept an instruction
//   rf_waddr_wb_o          register file write address
//   rf_wdata_wb_o          register file write data
//   rf_we_wb_o             register file write enable
//   dummy_instr_wb_o       held instruction is a dummy
//   outstanding_load_wb_o  a load is held in WB awaiting data
//   instr_done_wb_o        pulse: held instruction retires
//   load_err_wb_o          pulse: held load retired with a bus error
//   perf_load_stall_o      saturating count of load-wait cycles
// ----------------------------------------------------------------------------
module ibex_rf_writeback_stage #(
    parameter int unsigned DataWidth         = 32,
    parameter bit          DummyInstructions = 1'b0,
    parameter int unsigned StallCntWidth     = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_wb_i,
    input  logic                     instr_is_load_i,
    input  logic                     dummy_instr_id_i,
    input  logic [4:0]               rf_waddr_ex_i,
    input  logic [DataWidth-1:0]     rf_wdata_ex_i,
    input  logic                     rf_we_ex_i,
    input  logic                     lsu_resp_valid_i,
    input  logic [DataWidth-1:0]     lsu_rdata_i,
    input  logic                     lsu_resp_err_i,
    output logic                     ready_wb_o,
    output logic [4:0]               rf_waddr_wb_o,
    output logic [DataWidth-1:0]     rf_wdata_wb_o,
    output logic                     rf_we_wb_o,
    output logic                     dummy_instr_wb_o,
    output logic                     outstanding_load_wb_o,
    output logic                     instr_done_wb_o,
    output logic                     load_err_wb_o,
    output logic [StallCntWidth-1:0] perf_load_stall_o
);

    localparam logic [1:0] WB_EMPTY     = 2'd0;
    localparam logic [1:0] WB_HOLD      = 2'd1;
    localparam logic [1:0] WB_WAIT_LOAD = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [4:0]               waddr_q;
    logic [DataWidth-1:0]     wdata_q;
    logic                     we_q;
    logic                     is_load_q;
    logic                     dummy_q;
    logic [StallCntWidth-1:0] stall_cnt_q, stall_cnt_d;

    logic wb_done;
    logic capture;
    logic dummy_in;
    logic load_err;

    assign wb_done    = (state_q == WB_HOLD) |
                        ((state_q == WB_WAIT_LOAD) & lsu_resp_valid_i);
    assign ready_wb_o = (state_q == WB_EMPTY) | wb_done;
    assign capture    = en_wb_i & ready_wb_o;

    // The dummy flag only travels through the stage when dummies exist.
    assign dummy_in   = DummyInstructions ? dummy_instr_id_i : 1'b0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_EMPTY, WB_HOLD, WB_WAIT_LOAD: begin
                // A new capture replaces the retiring entry in the same
                // cycle, so back-to-back instructions have no bubble.
                if (capture) begin
                    state_d = instr_is_load_i ? WB_WAIT_LOAD : WB_HOLD;
                end else if (wb_done) begin
                    state_d = WB_EMPTY;
                end
            end
            default: state_d = WB_EMPTY;
        endcase
    end

    // Count only the cycles where the load is still waiting. The response
    // cycle itself is not a stall. The counter sticks at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == WB_WAIT_LOAD) && !lsu_resp_valid_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + StallCntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= WB_EMPTY;
            waddr_q     <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            is_load_q   <= 1'b0;
            dummy_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            if (capture) begin
                waddr_q   <= rf_waddr_ex_i;
                wdata_q   <= rf_wdata_ex_i;
                we_q      <= rf_we_ex_i;
                is_load_q <= instr_is_load_i;
                dummy_q   <= dummy_in;
            end
        end
    end

    assign load_err = is_load_q & lsu_resp_err_i;

    // Write port. Writes to x0 pass straight through. The register file
    // drops them unless they are dummy writes.
    assign rf_we_wb_o            = wb_done & we_q & ~load_err;
    assign rf_wdata_wb_o         = is_load_q ? lsu_rdata_i : wdata_q;
    assign rf_waddr_wb_o         = waddr_q;
    assign dummy_instr_wb_o      = dummy_q & (state_q != WB_EMPTY);

    assign instr_done_wb_o       = wb_done;
    assign load_err_wb_o         = wb_done & load_err;
    assign outstanding_load_wb_o = (state_q == WB_WAIT_LOAD);
    assign perf_load_stall_o     = stall_cnt_q;

    // Protocol checks: EX must respect ready_wb_o. A load response is only
    // legal while a load is waiting.
    en_while_busy_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(en_wb_i && !ready_wb_o));
    spurious_resp_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(lsu_resp_valid_i && (state_q != WB_WAIT_LOAD)));

endmodule

// File: tb/tb_ibex_rf_writeback_stage.sv
// ----------------------------------------------------------------------------
// Testbench for ibex_rf_writeback_stage.
// dut   : DummyInstructions=1, StallCntWidth=16
// dut_s : DummyInstructions=0, StallCntWidth=4 (same stimulus)
// Both instances get the same stimulus. Retire records are checked against
// an expected queue.
// ----------------------------------------------------------------------------
module tb_ibex_rf_writeback_stage;

    localparam int DW    = 32;
    localparam int REC_W = 5 + DW + 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          en_wb, is_load, dummy_id, we_ex, resp_valid, resp_err;
    logic [4:0]    waddr_ex;
    logic [DW-1:0] wdata_ex, rdata;

    logic          ready, rf_we, dummy_wb, outstanding, done, load_err;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [15:0]   perf;

    logic          ready_s, rf_we_s, dummy_wb_s, outstanding_s, done_s, load_err_s;
    logic [4:0]    rf_waddr_s;
    logic [DW-1:0] rf_wdata_s;
    logic [3:0]    perf_s;

    ibex_rf_writeback_stage #(.DataWidth(DW), .DummyInstructions(1'b1), .StallCntWidth(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .en_wb_i(en_wb), .instr_is_load_i(is_load),
        .dummy_instr_id_i(dummy_id), .rf_waddr_ex_i(waddr_ex), .rf_wdata_ex_i(wdata_ex),
        .rf_we_ex_i(we_ex), .lsu_resp_valid_i(resp_valid), .lsu_rdata_i(rdata),
        .lsu_resp_err_i(resp_err), .ready_wb_o(ready), .rf_waddr_wb_o(rf_waddr),
        .rf_wdata_wb_o(rf_wdata), .rf_we_wb_o(rf_we), .dummy_instr_wb_o(dummy_wb),
        .outstanding_load_wb_o(outstanding), .instr_done_wb_o(done),
        .load_err_wb_o(load_err), .perf_load_stall_o(perf)
    );

    ibex_rf_writeback_stage #(.DataWidth(DW), .DummyInstructions(1'b0), .StallCntWidth(4)) dut_s (
        .clk_i(clk), .rst_ni(rst_ni), .en_wb_i(en_wb), .instr_is_load_i(is_load),
        .dummy_instr_id_i(dummy_id), .rf_waddr_ex_i(waddr_ex), .rf_wdata_ex_i(wdata_ex),
        .rf_we_ex_i(we_ex), .lsu_resp_valid_i(resp_valid), .lsu_rdata_i(rdata),
        .lsu_resp_err_i(resp_err), .ready_wb_o(ready_s), .rf_waddr_wb_o(rf_waddr_s),
        .rf_wdata_wb_o(rf_wdata_s), .rf_we_wb_o(rf_we_s), .dummy_instr_wb_o(dummy_wb_s),
        .outstanding_load_wb_o(outstanding_s), .instr_done_wb_o(done_s),
        .load_err_wb_o(load_err_s), .perf_load_stall_o(perf_s)
    );

    // ---------------- scoreboard state ----------------
    logic [REC_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Model of the stage as seen from the bench.
    logic       m_wait = 1'b0;
    int         stall_exp = 0;
    logic [4:0] pend_waddr;
    logic       pend_we, pend_dm;

    function automatic logic [REC_W-1:0] mk_rec(input logic [4:0] a, input logic [DW-1:0] d,
                                                input logic we, input logic err, input logic dm);
        return {a, d, we, err, dm};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic ld, input logic [4:0] a, input logic [DW-1:0] d,
                         input logic we, input logic dm);
        en_wb = 1'b1; is_load = ld; waddr_ex = a; wdata_ex = d; we_ex = we; dummy_id = dm;
        if (ld) begin
            pend_waddr = a; pend_we = we; pend_dm = dm;
        end else begin
            exp_q.push_back(mk_rec(a, d, we, 1'b0, dm));
        end
    endtask

    task automatic no_issue();
        en_wb = 1'b0; is_load = 1'b0; dummy_id = 1'b0; we_ex = 1'b0;
        waddr_ex = 5'($urandom); wdata_ex = $urandom;
    endtask

    task automatic respond(input logic [DW-1:0] rd, input logic e);
        resp_valid = 1'b1; rdata = rd; resp_err = e;
        exp_q.push_back(mk_rec(pend_waddr, rd, pend_we & ~e, e, pend_dm));
    endtask

    task automatic no_resp();
        resp_valid = 1'b0; resp_err = 1'b0; rdata = $urandom;
    endtask

    // Called once per cycle after the checks, using the inputs of that cycle.
    task automatic model_update();
        if (m_wait && !resp_valid) stall_exp++;
        if (en_wb && is_load) m_wait = 1'b1;
        else if (resp_valid) m_wait = 1'b0;
    endtask

    task automatic check_perf(input string tag);
        chk({tag, "_perf16"}, 64'(perf), (stall_exp > 65535) ? 64'hFFFF : 64'(stall_exp));
        chk({tag, "_perf4"}, 64'(perf_s), (stall_exp > 15) ? 64'hF : 64'(stall_exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(ready), 64'd1);
        chk({tag, "_we"}, 64'(rf_we), 64'd0);
        chk({tag, "_waddr"}, 64'(rf_waddr), 64'd0);
        chk({tag, "_wdata"}, 64'(rf_wdata), 64'd0);
        chk({tag, "_dummy"}, 64'(dummy_wb), 64'd0);
        chk({tag, "_outst"}, 64'(outstanding), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_lerr"}, 64'(load_err), 64'd0);
        chk({tag, "_perf"}, 64'(perf), 64'd0);
        chk({tag, "_ready_s"}, 64'(ready_s), 64'd1);
        chk({tag, "_perf_s"}, 64'(perf_s), 64'd0);
    endtask

    // ---------------- retire monitor ----------------
    always @(negedge clk) begin
        logic [REC_W-1:0] e, act, act_s;
        #2;
        if (rst_ni) begin
            chk("we_without_done", 64'(rf_we & ~done), 64'd0);
            if (done) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL retire_unexpected: observed waddr %0d wdata %0h expected no retire",
                           rf_waddr, rf_wdata);
                end
                if (exp_q.size() != 0) begin
                    e     = exp_q.pop_front();
                    act   = mk_rec(rf_waddr, rf_wdata, rf_we, load_err, dummy_wb);
                    act_s = mk_rec(rf_waddr_s, rf_wdata_s, rf_we_s, load_err_s, dummy_wb_s);
                    chk("retire_rec", 64'(act), 64'(e));
                    chk("retire_rec_s", 64'(act_s), 64'({e[REC_W-1:1], 1'b0}));
                    chk("retire_done_s", 64'(done_s), 64'd1);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic ld, b2b;
        int   lat;
        no_issue(); no_resp();

        // Reset state
        #1;
        check_reset_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst_ni = 1'b1;

        // ALU op to x5
        @(negedge clk); issue(1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0); no_resp();
        #1; chk("alu_ready_empty", 64'(ready), 64'd1); model_update();
        @(negedge clk); no_issue();
        #1;
        chk("alu_we", 64'(rf_we), 64'd1);
        chk("alu_waddr", 64'(rf_waddr), 64'd5);
        chk("alu_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        chk("alu_done", 64'(done), 64'd1);
        chk("alu_ready", 64'(ready), 64'd1);
        model_update();

        // Load to x7, response three cycles later
        @(negedge clk); issue(1'b1, 5'd7, 32'h0, 1'b1, 1'b0); no_resp();
        #1; model_update();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); no_issue(); no_resp();
            #1;
            chk("ld_ready_low", 64'(ready), 64'd0);
            chk("ld_outstanding", 64'(outstanding), 64'd1);
            chk("ld_no_write", 64'(rf_we), 64'd0);
            check_perf("ld_wait");
            model_update();
        end
        @(negedge clk); no_issue(); respond(32'h12345678, 1'b0);
        #1;
        chk("ld_resp_outst", 64'(outstanding), 64'd1);
        chk("ld_resp_ready", 64'(ready), 64'd1);
        chk("ld_resp_we", 64'(rf_we), 64'd1);
        chk("ld_resp_wdata", 64'(rf_wdata), 64'h12345678);
        check_perf("ld_resp");
        model_update();
        @(negedge clk); no_issue(); no_resp();
        #1; check_perf("ld_after"); chk("ld_after_stall2", 64'(perf), 64'd2);
        chk("ld_after_outst", 64'(outstanding), 64'd0); model_update();

        // Load with bus error
        @(negedge clk); issue(1'b1, 5'd9, 32'h0, 1'b1, 1'b0); no_resp();
        #1; model_update();
        @(negedge clk); no_issue(); respond(32'hAAAA5555, 1'b1);
        #1;
        chk("err_we", 64'(rf_we), 64'd0);
        chk("err_lerr", 64'(load_err), 64'd1);
        chk("err_done", 64'(done), 64'd1);
        model_update();
        @(negedge clk); no_issue(); no_resp();
        #1;
        chk("err_empty_ready", 64'(ready), 64'd1);
        chk("err_empty_outst", 64'(outstanding), 64'd0);
        chk("err_empty_done", 64'(done), 64'd0);
        model_update();

        // Back-to-back: load x3, then ALU x4 captured in the response cycle
        @(negedge clk); issue(1'b1, 5'd3, 32'h0, 1'b1, 1'b0); no_resp();
        #1; model_update();
        @(negedge clk); no_issue(); no_resp();
        #1; chk("b2b_wait_ready", 64'(ready), 64'd0); model_update();
        @(negedge clk); respond(32'hCAFEF00D, 1'b0); issue(1'b0, 5'd4, 32'h44444444, 1'b1, 1'b0);
        #1;
        chk("b2b_resp_ready", 64'(ready), 64'd1);
        chk("b2b_resp_waddr", 64'(rf_waddr), 64'd3);
        model_update();
        @(negedge clk); no_issue(); no_resp();
        #1;
        chk("b2b_alu_we", 64'(rf_we), 64'd1);
        chk("b2b_alu_waddr", 64'(rf_waddr), 64'd4);
        chk("b2b_alu_wdata", 64'(rf_wdata), 64'h44444444);
        model_update();

        // Non-writing ALU op followed directly by another ALU op
        @(negedge clk); issue(1'b0, 5'd10, 32'h1111, 1'b0, 1'b0); no_resp();
        #1; model_update();
        @(negedge clk); issue(1'b0, 5'd11, 32'h2222, 1'b1, 1'b0);
        #1; chk("nowe_we", 64'(rf_we), 64'd0); chk("nowe_done", 64'(done), 64'd1); model_update();
        @(negedge clk); no_issue();
        #1; chk("alu2_waddr", 64'(rf_waddr), 64'd11); model_update();

        // Dummy instruction to x0
        @(negedge clk); issue(1'b0, 5'd0, 32'h0D0D0D0D, 1'b1, 1'b1); no_resp();
        #1; chk("dummy_pre", 64'(dummy_wb), 64'd0); model_update();
        @(negedge clk); no_issue();
        #1;
        chk("dummy_flag", 64'(dummy_wb), 64'd1);
        chk("dummy_we", 64'(rf_we), 64'd1);
        chk("dummy_waddr", 64'(rf_waddr), 64'd0);
        chk("dummy_masked_s", 64'(dummy_wb_s), 64'd0);
        model_update();
        @(negedge clk); no_issue();
        #1; chk("dummy_cleared", 64'(dummy_wb), 64'd0); model_update();

        // Random traffic
        for (int n = 0; n < 24; n++) begin
            ld = 1'($urandom_range(0, 1));
            @(negedge clk); issue(ld, 5'($urandom), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))); no_resp();
            #1; chk("rnd_issue_ready", 64'(ready), 64'd1); model_update();
            if (ld) begin
                lat = $urandom_range(1, 3);
                for (int k = 1; k < lat; k++) begin
                    @(negedge clk); no_issue(); no_resp();
                    #1; chk("rnd_wait_outst", 64'(outstanding), 64'd1); check_perf("rnd_wait"); model_update();
                end
                b2b = 1'($urandom_range(0, 1));
                @(negedge clk); respond($urandom, ($urandom_range(0, 5) == 0));
                if (b2b) issue(1'b0, 5'($urandom), $urandom, 1'b1, 1'($urandom_range(0, 1)));
                else no_issue();
                #1; check_perf("rnd_resp"); model_update();
            end
        end
        @(negedge clk); no_issue(); no_resp();
        #1; model_update();
        @(negedge clk);
        #1; chk("rnd_drained_ready", 64'(ready), 64'd1); model_update();

        // Long stall: both counters saturate
        @(negedge clk); issue(1'b1, 5'd12, 32'h0, 1'b1, 1'b0); no_resp();
        #1; model_update();
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk); no_issue(); no_resp();
            #1; model_update();
        end
        @(negedge clk); no_issue(); no_resp();
        #1;
        chk("sat_perf16", 64'(perf), 64'hFFFF);
        chk("sat_perf4", 64'(perf_s), 64'hF);
        model_update();
        @(negedge clk); respond(32'h5A5A5A5A, 1'b0);
        #1; model_update();
        @(negedge clk); no_issue(); no_resp();
        #1; chk("sat_hold", 64'(perf), 64'hFFFF); model_update();

        // Reset while a load waits: no write, outputs return to reset values
        @(negedge clk); issue(1'b1, 5'd13, 32'h0, 1'b1, 1'b0); no_resp();
        #1; model_update();
        @(negedge clk); no_issue(); no_resp();
        #1; chk("rst_pre_outst", 64'(outstanding), 64'd1); model_update();
        @(negedge clk); rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        m_wait = 1'b0; stall_exp = 0;
        @(negedge clk); rst_ni = 1'b1;
        #1; check_reset_outputs("postrst");
        @(negedge clk); issue(1'b0, 5'd14, 32'h77778888, 1'b1, 1'b0);
        #1; model_update();
        @(negedge clk); no_issue();
        #1; chk("postrst_alu_waddr", 64'(rf_waddr), 64'd14); model_update();

        @(negedge clk); @(negedge clk);
        #3;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
